// File: rtl/ctrl_seq_pkg.sv
// typedefs: shared opcode and phase encodings for the VeriRISC sequencer.
package typedefs;
    typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
    typedef enum logic [3:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED
    } state_t;
    function automatic logic is_aluop(input opcode_t op);
        return op inside {ADD, AND, XOR, LDA};
    endfunction
endpackage

// File: rtl/ctrl_seq_wait_timer.sv
// wait_timer: counts stalled cycles in a memory phase, saturating at TIMEOUT.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_,
    input  logic clr,
    input  logic stall,
    output logic expired
);
    localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign expired = (TIMEOUT != 0) && (cnt_q == W'(TIMEOUT));
    assign cnt_d = clr ? '0 : (stall && cnt_q != W'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_)
        if (!rst_) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: eight-phase fetch/execute sequencer with memory wait states,
// bus timeout, persistent halt, single-step and retired-instruction count.
module ctrl_seq
    import typedefs::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  opcode_t          opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             resume,
    input  logic             step_en,
    input  logic             step,
    output logic             mem_rd,
    output logic             load_ir,
    output logic             halt,
    output logic             inc_pc,
    output logic             load_ac,
    output logic             load_pc,
    output logic             mem_wr,
    output logic             bus_err,
    output state_t           state_o,
    output logic [CNT_W-1:0] instr_cnt
);
    state_t state_q, state_d;
    logic bus_err_q, bus_err_d, expired;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic aluop, mem_phase, stall;

    assign aluop = is_aluop(opcode);
    assign mem_phase = (state_q == INST_FETCH) || (state_q == OP_FETCH && aluop) ||
                       (state_q == STORE && opcode == STO);
    assign stall = mem_phase && !mem_ready;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk), .rst_(rst_), .clr(state_d != state_q), .stall(stall), .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            INST_ADDR:  state_d = (step_en && !step) ? INST_ADDR : INST_FETCH;
            INST_FETCH: state_d = INST_LOAD;
            INST_LOAD:  state_d = IDLE;
            IDLE:       state_d = OP_ADDR;
            OP_ADDR:    state_d = (opcode == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   state_d = ALU_OP;
            ALU_OP:     state_d = STORE;
            STORE:      state_d = INST_ADDR;
            HALTED:     state_d = resume ? INST_ADDR : HALTED;
            default:    state_d = INST_ADDR;
        endcase
        // a stalled memory phase holds until ready, or aborts once the timer expires
        if (stall) state_d = expired ? HALTED : state_q;
    end

    assign bus_err_d = (state_q == HALTED && resume) ? 1'b0 : (stall && expired) ? 1'b1 : bus_err_q;
    assign cnt_d = (state_q == STORE && state_d == INST_ADDR) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_)
        if (!rst_) begin
            state_q   <= INST_ADDR;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end

    always_comb begin
        {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = '0;
        case (state_q)
            INST_FETCH: mem_rd = 1'b1;
            INST_LOAD, IDLE: {mem_rd, load_ir} = 2'b11;
            OP_ADDR: {inc_pc, halt} = {1'b1, opcode == HLT};
            OP_FETCH: mem_rd = aluop;
            ALU_OP: {mem_rd, load_ac, inc_pc, load_pc} = {aluop, aluop, opcode == SKZ && zero, opcode == JMP};
            STORE: {mem_rd, load_ac, inc_pc, load_pc, mem_wr} = {aluop, aluop, opcode == JMP, opcode == JMP, opcode == STO};
            HALTED: halt = 1'b1;
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign bus_err   = bus_err_q;
    assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed scoreboard bench for ctrl_seq (TIMEOUT=15, CNT_W=2).
module tb_ctrl_seq;
    import typedefs::*;

    logic clk = 1'b0, rst_ = 1'b0;
    opcode_t opcode = HLT;
    logic zero = 1'b0, mem_ready = 1'b1, resume = 1'b0, step_en = 1'b0, step = 1'b0;
    logic mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, bus_err;
    state_t state_o;
    logic [1:0] instr_cnt;

    ctrl_seq #(.TIMEOUT(15), .CNT_W(2)) dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .resume(resume), .step_en(step_en), .step(step), .mem_rd(mem_rd), .load_ir(load_ir),
        .halt(halt), .inc_pc(inc_pc), .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
        .bus_err(bus_err), .state_o(state_o), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        state_t     st;
        logic [6:0] sb;
        logic       be;
        logic [1:0] cnt;
    } exp_t;

    localparam logic [55:0] P_ALU = {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100};
    localparam logic [55:0] P_STO = {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0001000, 7'b0000000, 7'b0000000, 7'b0000001};
    localparam logic [55:0] P_JMP = {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0001000, 7'b0000000, 7'b0000010, 7'b0001010};
    localparam logic [55:0] P_SKZ = {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                                     7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000};

    exp_t q[$];
    exp_t e, g;
    event smp;
    int n_chk = 0, n_pass = 0;
    logic be_m = 1'b0;
    logic [1:0] cnt_m = 2'd0;

    always begin
        @(negedge clk or smp);
        if (q.size() != 0) begin
            e = q.pop_front();
            g = {state_o, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, bus_err, instr_cnt};
            n_chk++;
            if (g === e) n_pass++;
            else $display("FAIL phase t=%0t: got st=%0d sb=%b be=%b cnt=%0d, expected st=%0d sb=%b be=%b cnt=%0d",
                          $time, g.st, g.sb, g.be, g.cnt, e.st, e.sb, e.be, e.cnt);
        end
    end

    function automatic logic [6:0] ph(input logic [55:0] p, input int i);
        return p[55-7*i -: 7];
    endfunction

    task automatic cyc(input state_t s, input logic [6:0] sb, input logic mr, input logic rs, input logic stp);
        mem_ready = mr;
        resume    = rs;
        step      = stp;
        q.push_back(exp_t'({s, sb, be_m, cnt_m}));
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input opcode_t op, input logic z, input logic [55:0] p,
                         input int s_if, input int s_of, input int s_st, input int park);
        opcode = op;
        zero   = z;
        for (int k = 0; k < park; k++) cyc(INST_ADDR, 7'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            int n;
            n = (i == 1) ? s_if : (i == 5) ? s_of : (i == 7) ? s_st : -1;
            for (int k = 0; k < n; k++) cyc(state_t'(4'(i)), ph(p, i), 1'b0, 1'b0, 1'b0);
            cyc(state_t'(4'(i)), ph(p, i), n >= 0, 1'b0, i == 0 && step_en);
        end
        cnt_m++;
    endtask

    initial begin
        #2;
        q.push_back(exp_t'({INST_ADDR, 7'b0, 1'b0, 2'b0}));
        ->smp;
        @(posedge clk);
        #1 rst_ = 1'b1;
        instr(LDA, 1'b0, P_ALU, 0, 0, -1, 0);
        instr(ADD, 1'b0, P_ALU, 0, 0, -1, 0);
        instr(STO, 1'b0, P_STO, 0, -1, 0, 0);
        instr(JMP, 1'b0, P_JMP, 0, -1, -1, 0);
        instr(SKZ, 1'b1, P_SKZ, 3, -1, -1, 0);
        instr(AND, 1'b0, P_ALU, 0, 15, -1, 0);
        instr(STO, 1'b0, P_STO, 0, -1, 2, 0);
        opcode = ADD;
        zero   = 1'b0;
        for (int i = 0; i < 5; i++) cyc(state_t'(4'(i)), ph(P_ALU, i), 1'b1, i == 2, 1'b0);
        for (int k = 0; k < 16; k++) cyc(OP_FETCH, 7'b1000000, 1'b0, 1'b0, 1'b0);
        be_m = 1'b1;
        cyc(HALTED, 7'b0010000, 1'b0, 1'b0, 1'b0);
        cyc(HALTED, 7'b0010000, 1'b1, 1'b0, 1'b0);
        cyc(HALTED, 7'b0010000, 1'b1, 1'b1, 1'b0);
        be_m = 1'b0;
        opcode = HLT;
        for (int i = 0; i < 4; i++) cyc(state_t'(4'(i)), ph(P_ALU, i), 1'b1, 1'b0, 1'b0);
        cyc(OP_ADDR, 7'b0011000, 1'b1, 1'b0, 1'b0);
        cyc(HALTED, 7'b0010000, 1'b1, 1'b0, 1'b0);
        cyc(HALTED, 7'b0010000, 1'b1, 1'b0, 1'b1);
        cyc(HALTED, 7'b0010000, 1'b1, 1'b1, 1'b0);
        step_en = 1'b1;
        instr(LDA, 1'b0, P_ALU, 0, 0, -1, 3);
        instr(JMP, 1'b0, P_JMP, 0, -1, -1, 1);
        instr(STO, 1'b0, P_STO, 1, -1, 0, 2);
        instr(XOR, 1'b0, P_ALU, 0, 0, -1, 0);
        instr(ADD, 1'b0, P_ALU, 0, 1, -1, 1);
        step_en = 1'b0;
        instr(SKZ, 1'b1, P_SKZ, 0, -1, -1, 0);
        opcode = STO;
        for (int i = 0; i < 7; i++) cyc(state_t'(4'(i)), ph(P_STO, i), 1'b1, 1'b0, 1'b0);
        cyc(STORE, 7'b0000001, 1'b0, 1'b0, 1'b0);
        cyc(STORE, 7'b0000001, 1'b0, 1'b0, 1'b0);
        rst_ = 1'b0;
        cnt_m = 2'd0;
        #1;
        q.push_back(exp_t'({INST_ADDR, 7'b0, 1'b0, 2'b0}));
        ->smp;
        @(posedge clk);
        #1 rst_ = 1'b1;
        instr(JMP, 1'b0, P_JMP, 0, -1, -1, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) $display("FAIL end: %0d expectations never sampled", q.size());
        if (n_pass != n_chk) $display("FAIL end: %0d of %0d checks failed", n_chk - n_pass, n_chk);
        else $display("PASS: %0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised successor of the VeriRISC instruction-sequencing controller. It runs the eight-phase fetch/execute cycle and adds four things:
- Memory wait-state handshake (`mem_ready`) with a bus timeout.
- A persistent HALTED state, left only on a `resume` pulse.
- A single-step debug mode.
- A retired-instruction counter.

It sits between the instruction register/ALU datapath and the memory, and drives the same strobe set as the existing controller.

## Interface
- `TIMEOUT`, 15: maximum cycles a memory phase may stall before `bus_err`; 0 disables the timeout.
- `CNT_W`, 16: width of `instr_cnt`.
- `clk`  in  1  clock.
- `rst_`  in  1  reset, asynchronous, active-low.
- `opcode`  in  `opcode_t`  current IR opcode.
- `zero`  in  1  accumulator-zero flag.
- `mem_ready`  in  1  memory has completed the current read/write.
- `resume`  in  1  one-cycle pulse; leave HALTED.
- `step_en`  in  1  single-step mode enable.
- `step`  in  1  one-cycle pulse; release one instruction in step mode.
- `mem_rd`, `load_ir`, `halt`, `inc_pc`, `load_ac`, `load_pc`, `mem_wr`  out  1 each  datapath strobes.
- `bus_err`  out  1  sticky memory-timeout flag.
- `state_o`  out  `state_t`  current phase (debug).
- `instr_cnt`  out  `CNT_W`  retired-instruction count.

## Operation
- States: INST_ADDR → INST_FETCH → INST_LOAD → IDLE → OP_ADDR → OP_FETCH → ALU_OP → STORE → INST_ADDR, plus HALTED.
- ALUOP means `opcode` is one of ADD, AND, XOR, LDA.
- Strobe decode (all strobes not listed are 0):
  - INST_ADDR: none.
  - INST_FETCH: `mem_rd`.
  - INST_LOAD, IDLE: `mem_rd`, `load_ir`.
  - OP_ADDR: `inc_pc`; `halt` = (opcode==HLT).
  - OP_FETCH: `mem_rd` = ALUOP.
  - ALU_OP: `mem_rd` = `load_ac` = ALUOP; `inc_pc` = (SKZ && zero); `load_pc` = JMP.
  - STORE: `mem_rd` = `load_ac` = ALUOP; `inc_pc` = `load_pc` = JMP; `mem_wr` = STO.
  - HALTED: `halt` = 1, all others 0.
- Memory phases are INST_FETCH always, OP_FETCH when ALUOP, and STORE when STO.
  - A memory phase holds its state, with strobes steady, while `mem_ready` = 0.
  - It advances on the first cycle `mem_ready` = 1.
- Wait timer:
  - Counts cycles spent stalled in the current memory phase; clears on every state change.
  - If `TIMEOUT` ≠ 0 and the count reaches `TIMEOUT` with `mem_ready` still 0, the next state is HALTED and `bus_err` is set.
- HLT: OP_ADDR with opcode==HLT goes next to HALTED, not OP_FETCH.
- HALTED:
  - Stays until `resume` = 1, then goes to INST_ADDR on the next edge and clears `bus_err`.
  - `resume` is ignored in all other states.
- Step mode:
  - With `step_en` = 1, INST_ADDR holds until `step` = 1.
  - `step` and `step_en` asserted in the same cycle: advance.
  - `step` is ignored outside INST_ADDR and when `step_en` = 0.
  - Deasserting `step_en` mid-instruction has no effect on that instruction.
- `instr_cnt`:
  - Increments on each STORE → INST_ADDR transition.
  - Wraps from 2^CNT_W−1 to 0.
  - HLT instructions and timed-out instructions are not counted.

## Timing
- State register updates on posedge `clk`; strobes are a combinational decode of the registered state plus `opcode` and `zero`, so they are valid the same cycle `state_o` shows the phase.
- Without stalls an instruction takes 8 cycles; each stall cycle adds 1.
- Timeout: the transition to HALTED happens on the edge after `TIMEOUT` stalled cycles, i.e. the stalled phase lasts `TIMEOUT` + 1 cycles total.
- `mem_ready` = 1 on the cycle the count reaches `TIMEOUT` wins: the FSM advances normally and no error is raised.
- Reset (asynchronous, any time, including mid-stall or in HALTED):
  - state = INST_ADDR, wait count = 0, `bus_err` = 0, `instr_cnt` = 0.
  - All strobes 0.
  - `rst_` dominates `resume` and `step`.
- `bus_err` rises on the same edge HALTED is entered.

## Structure
- Package `typedefs`:
  - `opcode_t`, unchanged.
  - `state_t` extended: existing eight values keep encodings 0–7; HALTED = 8; 4-bit base type.
- Sub-module `wait_timer`:
  - Parameter `TIMEOUT`.
  - Inputs `clk`, `rst_`, `clr`, `stall`.
  - Output `expired`.
  - Counter saturates at `TIMEOUT`.

## Test plan
- `mem_ready` tied 1, program LDA, ADD, STO, JMP → each instruction 8 cycles; exact strobe pattern per phase; `instr_cnt` = 4.
- INST_FETCH with `mem_ready` low for 3 cycles, `TIMEOUT` = 15 → INST_FETCH lasts 4 cycles with `mem_rd` = 1; `bus_err` = 0.
- OP_FETCH of ADD with `mem_ready` held 0 → HALTED after 16 cycles in OP_FETCH; `bus_err` = 1, `halt` = 1; `resume` → INST_ADDR next cycle, `bus_err` = 0.
- HLT opcode → OP_ADDR `halt` = 1 then HALTED; `instr_cnt` unchanged; `step` pulse ignored; `resume` restarts.
- `step_en` = 1 → FSM parks in INST_ADDR; each `step` pulse yields exactly one 8-cycle instruction; `CNT_W` = 2 with 5 steps → `instr_cnt` = 1 (wrap).
- `rst_` low during a STORE stall → all outputs 0, state INST_ADDR, counters 0 immediately, independent of `clk`.
